adder_arbiter: RTL and testbench

- Shares one 32-bit combinational adder instance (HanCarlson-class) between two requesters using valid/ready handshakes.
- Round-robin arbitration; one operation in flight at a time.
- Drives the adder operand registers and waits a programmable settle time.
- Captures sum/cout into a per-requester response register and holds it until the owner accepts it.

---
 rtl/adder_arbiter_if.sv | 54 +++++
 rtl/adder_arbiter.sv | 113 +++++++++++
 tb/tb_adder_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// Handshake and shared-adder bundle for adder_arbiter.
// The requester/adder side uses the master modport; the arbiter uses slave.
interface adder_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;
  logic             req0_ready;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_sum;
  logic             rsp0_cout;
  logic             rsp0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;
  logic             req1_ready;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_sum;
  logic             rsp1_cout;
  logic             rsp1_ready;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  logic             busy;
  logic             owner;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin, rsp0_ready,
    input  req0_ready, rsp0_valid, rsp0_sum, rsp0_cout,
    output req1_valid, req1_a, req1_b, req1_cin, rsp1_ready,
    input  req1_ready, rsp1_valid, rsp1_sum, rsp1_cout,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  busy, owner
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin, rsp0_ready,
    output req0_ready, rsp0_valid, rsp0_sum, rsp0_cout,
    input  req1_valid, req1_a, req1_b, req1_cin, rsp1_ready,
    output req1_ready, rsp1_valid, rsp1_sum, rsp1_cout,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output busy, owner
  );
endinterface

// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational adder.
// One operation is in flight at a time: operands are registered toward the
// adder, the result is captured after ADD_LAT cycles, and it is held in the
// owner's response register until the owner takes it.
module adder_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ADD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_INIT = 4'(ADD_LAT);

  state_t           state;
  logic [3:0]       cnt;
  logic             owner_q;
  logic             last_q;
  logic [WIDTH-1:0] add_a_q;
  logic [WIDTH-1:0] add_b_q;
  logic             add_cin_q;
  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_cout_q;
  logic [WIDTH-1:0] rsp_sum0_q;
  logic [WIDTH-1:0] rsp_sum1_q;

  logic             grant_valid;
  logic             grant;
  logic             owner_rsp_ready;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    grant       = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = bus.req1_valid;
    end
  end

  assign owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready = (state == IDLE) && grant_valid && !grant;
  assign bus.req1_ready = (state == IDLE) && grant_valid &&  grant;

  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.add_cin    = add_cin_q;
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_sum   = rsp_sum0_q;
  assign bus.rsp1_sum   = rsp_sum1_q;
  assign bus.rsp0_cout  = rsp_cout_q[0];
  assign bus.rsp1_cout  = rsp_cout_q[1];
  assign bus.busy       = (state != IDLE);
  assign bus.owner      = owner_q;

  // Control FSM: accept one request, let the adder settle, then hold the result for its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_cout_q  <= '0;
      rsp_sum0_q  <= '0;
      rsp_sum1_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            add_a_q   <= grant ? bus.req1_a   : bus.req0_a;
            add_b_q   <= grant ? bus.req1_b   : bus.req0_b;
            add_cin_q <= grant ? bus.req1_cin : bus.req0_cin;
            owner_q   <= grant;
            cnt       <= LAT_INIT;
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (owner_q) begin
              rsp_sum1_q <= bus.add_sum;
            end else begin
              rsp_sum0_q <= bus.add_sum;
            end
            rsp_cout_q[owner_q]  <= bus.add_cout;
            rsp_valid_q[owner_q] <= 1'b1;
            state                <= RESP;
          end
        end
        RESP: begin
          if (owner_rsp_ready) begin
            rsp_valid_q[owner_q] <= 1'b0;
            last_q               <= owner_q;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction/timestamp reference model.
module tb_adder_arbiter;

  localparam int WIDTH = 32;
  localparam int LAT   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  adder_arbiter_if #(.WIDTH(WIDTH)) bus ();
  adder_arbiter_if #(.WIDTH(WIDTH)) bus1 ();

  adder_arbiter #(.WIDTH(WIDTH), .ADD_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  adder_arbiter #(.WIDTH(WIDTH), .ADD_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Behavioural stand-ins for the shared adders
  assign {bus.add_cout, bus.add_sum} =
    {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{WIDTH{1'b0}}, bus.add_cin};
  assign {bus1.add_cout, bus1.add_sum} =
    {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {{WIDTH{1'b0}}, bus1.add_cin};

  always #5 clk = ~clk;

  // Reference model state: who is in flight, when it was accepted, what it owes
  bit             m_inflight;
  bit             m_owner;
  bit             m_last;
  int             m_edge;
  int             m_acc;
  logic [WIDTH:0] m_pending;
  logic [WIDTH:0] m_shown [2];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_inflight = 1'b0;
    m_owner    = 1'b0;
    m_last     = 1'b1;
    m_edge     = 0;
    m_acc      = 0;
    m_pending  = '0;
    m_shown[0] = '0;
    m_shown[1] = '0;
  endtask

  task automatic driveIdle();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0; bus.rsp0_ready = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  // One clock of traffic on the main DUT: drive, compare with the model, clock, advance the model
  task automatic applyStimulus(
    input bit v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0, input bit c0, input bit r0,
    input bit v1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1, input bit c1, input bit r1);
    bit exp_rdy0;
    bit exp_rdy1;
    bit win;
    bit showing;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_cin = c0; bus.rsp0_ready = r0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_cin = c1; bus.rsp1_ready = r1;
    #1;
    exp_rdy0 = 1'b0;
    exp_rdy1 = 1'b0;
    if (!m_inflight && (v0 || v1)) begin
      win      = (v0 && v1) ? !m_last : v1;
      exp_rdy0 = !win;
      exp_rdy1 = win;
    end
    showing = m_inflight && ((m_edge - m_acc) >= LAT);
    if (showing) m_shown[m_owner] = m_pending;
    checkOutput("req0_ready", bus.req0_ready, exp_rdy0);
    checkOutput("req1_ready", bus.req1_ready, exp_rdy1);
    checkOutput("rsp0_valid", bus.rsp0_valid, showing && !m_owner);
    checkOutput("rsp1_valid", bus.rsp1_valid, showing && m_owner);
    checkOutput("rsp0_sum", bus.rsp0_sum, m_shown[0][WIDTH-1:0]);
    checkOutput("rsp0_cout", bus.rsp0_cout, m_shown[0][WIDTH]);
    checkOutput("rsp1_sum", bus.rsp1_sum, m_shown[1][WIDTH-1:0]);
    checkOutput("rsp1_cout", bus.rsp1_cout, m_shown[1][WIDTH]);
    checkOutput("busy", bus.busy, m_inflight);
    checkOutput("owner", bus.owner, m_owner);
    @(posedge clk);
    m_edge++;
    if (exp_rdy0 || exp_rdy1) begin
      m_inflight = 1'b1;
      m_owner    = exp_rdy1;
      m_acc      = m_edge;
      m_pending  = exp_rdy1 ? ({1'b0, a1} + {1'b0, b1} + (WIDTH+1)'(c1))
                            : ({1'b0, a0} + {1'b0, b0} + (WIDTH+1)'(c0));
    end else if (showing && (m_owner ? r1 : r0)) begin
      m_inflight = 1'b0;
      m_last     = m_owner;
    end
    #1;
  endtask

  // Asynchronous reset pulse spanning one clock edge, with immediate-effect checks
  task automatic doReset();
    driveIdle();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_add_a", bus.add_a, 0);
    checkOutput("rst_add_b", bus.add_b, 0);
    checkOutput("rst_add_cin", bus.add_cin, 0);
    checkOutput("rst_rsp0_valid", bus.rsp0_valid, 0);
    checkOutput("rst_rsp1_valid", bus.rsp1_valid, 0);
    checkOutput("rst_owner", bus.owner, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    if (LAT < 1 || LAT > 15) begin
      $display("[TB] FAIL add_lat_cfg: got %0d, want 1..15", LAT);
      $fatal(1, "[TB] illegal ADD_LAT");
    end
    bus1.req0_valid = 1'b0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_cin = 1'b0; bus1.rsp0_ready = 1'b0;
    bus1.req1_valid = 1'b0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_cin = 1'b0; bus1.rsp1_ready = 1'b0;
    modelReset();
    doReset();

    // Single-cycle-latency instance: wraparound add with carry-out
    bus1.req0_valid = 1'b1; bus1.req0_a = 32'hFFFF_FFFF; bus1.req0_b = 32'h0000_0001; bus1.req0_cin = 1'b0;
    #1;
    checkOutput("l1_req0_ready", bus1.req0_ready, 1);
    checkOutput("l1_req1_ready", bus1.req1_ready, 0);
    @(posedge clk); #1;
    bus1.req0_valid = 1'b0;
    checkOutput("l1_busy", bus1.busy, 1);
    checkOutput("l1_rsp0_early", bus1.rsp0_valid, 0);
    @(posedge clk); #1;
    checkOutput("l1_rsp0_valid", bus1.rsp0_valid, 1);
    checkOutput("l1_rsp0_sum", bus1.rsp0_sum, 32'h0000_0000);
    checkOutput("l1_rsp0_cout", bus1.rsp0_cout, 1);
    checkOutput("l1_rsp1_valid", bus1.rsp1_valid, 0);
    bus1.rsp0_ready = 1'b1;
    @(posedge clk); #1;
    bus1.rsp0_ready = 1'b0;
    checkOutput("l1_rsp0_drop", bus1.rsp0_valid, 0);
    checkOutput("l1_idle", bus1.busy, 0);
    checkOutput("l1_cout_hold", bus1.rsp0_cout, 1);

    // Both requesters contend: req0 first, then req1, then req0 again
    applyStimulus(1, 5, 7, 1, 1, 1, 32'h8000_0000, 32'h8000_0000, 0, 1);
    repeat (LAT) applyStimulus(1, 5, 7, 1, 1, 1, 32'h8000_0000, 32'h8000_0000, 0, 1);
    checkOutput("t2_rsp0_valid", bus.rsp0_valid, 1);
    checkOutput("t2_rsp0_sum", bus.rsp0_sum, 13);
    checkOutput("t2_rsp0_cout", bus.rsp0_cout, 0);
    applyStimulus(1, 5, 7, 1, 1, 1, 32'h8000_0000, 32'h8000_0000, 0, 1);
    checkOutput("t2_grant1", bus.req1_ready, 1);
    repeat (LAT + 1) applyStimulus(1, 5, 7, 1, 1, 1, 32'h8000_0000, 32'h8000_0000, 0, 1);
    checkOutput("t2_rsp1_valid", bus.rsp1_valid, 1);
    checkOutput("t2_rsp1_sum", bus.rsp1_sum, 0);
    checkOutput("t2_rsp1_cout", bus.rsp1_cout, 1);
    applyStimulus(1, 5, 7, 1, 0, 1, 32'h8000_0000, 32'h8000_0000, 0, 1);
    checkOutput("t2_regrant0", bus.req0_ready, 1);

    // Owner stalls its response for six cycles while req1 keeps asking
    applyStimulus(1, 5, 7, 1, 0, 1, 32'h8000_0000, 32'h8000_0000, 0, 0);
    repeat (LAT) applyStimulus(1, 5, 7, 1, 0, 1, 32'h8000_0000, 32'h8000_0000, 0, 0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t3_hold_valid", bus.rsp0_valid, 1);
      checkOutput("t3_hold_sum", bus.rsp0_sum, 13);
      checkOutput("t3_req1_blocked", bus.req1_ready, 0);
      checkOutput("t3_busy", bus.busy, 1);
      applyStimulus(1, 5, 7, 1, 0, 1, 32'h8000_0000, 32'h8000_0000, 0, 1);
    end
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h8000_0000, 32'h8000_0000, 0, 1);
    checkOutput("t3_req1_next", bus.req1_ready, 1);
    repeat (LAT + 2) applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0000, 32'h8000_0000, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Operand registration and exact response latency on requester 1
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1234_5678, 32'h1111_1111, 0, 0);
    checkOutput("t4_add_a", bus.add_a, 32'h1234_5678);
    checkOutput("t4_add_b", bus.add_b, 32'h1111_1111);
    repeat (LAT - 1) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_rsp1_early", bus.rsp1_valid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_rsp1_valid", bus.rsp1_valid, 1);
    checkOutput("t4_rsp1_sum", bus.rsp1_sum, 32'h2345_6789);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset in the middle of an operation aborts it
    applyStimulus(1, 32'hDEAD_BEEF, 32'h0000_0011, 1, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    doReset();
    repeat (LAT + 2) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    applyStimulus(1, 32'h0000_00FF, 32'h0000_0001, 0, 1, 0, 0, 0, 0, 1);
    repeat (LAT + 1) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("t5_sum_after", bus.rsp0_sum, 32'h0000_0100);

    // A one-cycle req0 pulse during busy is never accepted
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0003, 32'h0000_0004, 0, 0);
    applyStimulus(1, 32'h0000_0009, 32'h0000_0009, 0, 1, 0, 0, 0, 0, 0);
    repeat (LAT) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("t6_req0_ready", bus.req0_ready, 0);
    checkOutput("t6_rsp0_valid", bus.rsp0_valid, 0);
    checkOutput("t6_idle", bus.busy, 0);
    checkOutput("t6_rsp1_sum", bus.rsp1_sum, 7);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 1), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 1), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (LAT + 2) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
